// File: rtl/bsg_manycore_outstanding_tracker.sv
// Outstanding remote-request tracker for a manycore tile.
// Counts issued requests that still owe a return packet, throttles issue at a
// credit limit, retires up to ret_ch_p returns per cycle and provides a fence
// handshake that stalls issue until every outstanding request has returned.
module bsg_manycore_outstanding_tracker #(
  parameter int max_out_p     = 32,
  parameter int ret_ch_p      = 2,
  parameter int data_width_p  = 32,
  parameter int cntr_width_lp = $clog2(max_out_p + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     req_v_i,
  output logic                     req_ready_o,
  input  logic [ret_ch_p-1:0]      ret_v_i,
  input  logic                     fence_v_i,
  output logic                     fence_done_o,
  input  logic                     clear_i,
  output logic [cntr_width_lp-1:0] count_o,
  output logic [data_width_p-1:0]  rdata_o,
  output logic                     idle_o,
  output logic [cntr_width_lp-1:0] max_seen_o,
  output logic                     underflow_o
);

  // Headroom so that count + 1 - (all channels) never wraps; the MSB is the sign.
  localparam int SumW = cntr_width_lp + $clog2(ret_ch_p + 1) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                   r_state;
  logic                     r_fence_done;
  logic [cntr_width_lp-1:0] r_count;
  logic [cntr_width_lp-1:0] r_max_seen;
  logic                     r_underflow;

  logic                     w_inc;
  logic [SumW-1:0]          w_dec;
  logic [SumW-1:0]          w_sum;
  logic                     w_underflow;
  logic [cntr_width_lp-1:0] w_next;

  // Credits are judged on registered state only, so a same-cycle return
  // never frees a credit until the following cycle.
  assign req_ready_o = (r_state == IDLE) && (r_count < cntr_width_lp'(max_out_p));
  assign w_inc       = req_v_i & req_ready_o;

  // Population count of the return channels retiring this cycle.
  always_comb begin
    w_dec = '0;
    for (int i = 0; i < ret_ch_p; i++) begin
      w_dec = w_dec + SumW'(ret_v_i[i]);
    end
  end

  assign w_sum       = SumW'(r_count) + SumW'(w_inc) - w_dec;
  assign w_underflow = w_sum[SumW-1];
  assign w_next      = w_underflow ? '0 : cntr_width_lp'(w_sum);

  // Outstanding count, high-water mark and sticky underflow flag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_count     <= '0;
      r_max_seen  <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_count <= w_next;
      if (clear_i) begin
        r_max_seen <= w_next;
      end else if (w_next > r_max_seen) begin
        r_max_seen <= w_next;
      end
      if (w_underflow) begin
        r_underflow <= 1'b1;
      end else if (clear_i) begin
        r_underflow <= 1'b0;
      end
    end
  end

  // Fence sequencer: IDLE -> DRAIN on a fence, DRAIN -> DONE once empty, DONE -> IDLE.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= IDLE;
      r_fence_done <= 1'b0;
    end else begin
      r_fence_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (fence_v_i) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (r_count == '0) begin
            r_state      <= DONE;
            r_fence_done <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign fence_done_o = r_fence_done;
  assign count_o      = r_count;
  assign rdata_o      = data_width_p'(r_count);
  assign idle_o       = (r_count == '0);
  assign max_seen_o   = r_max_seen;
  assign underflow_o  = r_underflow;

endmodule

// File: tb/tb_bsg_manycore_outstanding_tracker.sv
// Self-checking bench for bsg_manycore_outstanding_tracker.
// Two instances share one stimulus stream: A with the default credit limit
// and B with a limit of 4. An integer model of the tracker rules predicts
// every output of both instances each cycle.
module tb_bsg_manycore_outstanding_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       req_v;
  logic [1:0] ret_v;
  logic       fence_v;
  logic       clear;

  logic        readyA, doneA, idleA, ufA;
  logic [5:0]  countA, maxA;
  logic [31:0] rdataA;
  logic        readyB, doneB, idleB, ufB;
  logic [2:0]  countB, maxB;
  logic [31:0] rdataB;

  bsg_manycore_outstanding_tracker dutA (
    .clk_i(clk), .reset_n_i(reset_n), .req_v_i(req_v), .req_ready_o(readyA),
    .ret_v_i(ret_v), .fence_v_i(fence_v), .fence_done_o(doneA), .clear_i(clear),
    .count_o(countA), .rdata_o(rdataA), .idle_o(idleA), .max_seen_o(maxA),
    .underflow_o(ufA)
  );

  bsg_manycore_outstanding_tracker #(.max_out_p(4)) dutB (
    .clk_i(clk), .reset_n_i(reset_n), .req_v_i(req_v), .req_ready_o(readyB),
    .ret_v_i(ret_v), .fence_v_i(fence_v), .fence_done_o(doneB), .clear_i(clear),
    .count_o(countB), .rdata_o(rdataB), .idle_o(idleB), .max_seen_o(maxB),
    .underflow_o(ufB)
  );

  // Reference model: phase 0 = issuing, 1 = waiting for drain, 2 = fence done.
  int maxOut[2] = '{32, 4};
  int mCnt[2];
  int mMax[2];
  int mUf[2];
  int mPh[2];

  int checks = 0;
  int fails  = 0;

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int expReady(input int k);
    return (mPh[k] == 0 && mCnt[k] < maxOut[k]) ? 1 : 0;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mCnt[k] = 0; mMax[k] = 0; mUf[k] = 0; mPh[k] = 0;
    end
  endtask

  // Applies one clock edge of the tracker rules to both model instances.
  task automatic modelStep();
    int dec;
    int inc;
    int n;
    dec = int'(ret_v[0]) + int'(ret_v[1]);
    for (int k = 0; k < 2; k++) begin
      inc = (req_v && expReady(k) != 0) ? 1 : 0;
      n = mCnt[k] + inc - dec;
      if (n < 0) begin
        n = 0;
        mUf[k] = 1;
      end else if (clear) begin
        mUf[k] = 0;
      end
      if (clear) mMax[k] = n;
      else if (n > mMax[k]) mMax[k] = n;
      case (mPh[k])
        0: if (fence_v) mPh[k] = 1;
        1: if (mCnt[k] == 0) mPh[k] = 2;
        default: mPh[k] = 0;
      endcase
      mCnt[k] = n;
    end
  endtask

  task automatic checkOutput();
    checkVal("A.count", int'(countA), mCnt[0]);
    checkVal("A.rdata", int'(rdataA), mCnt[0]);
    checkVal("A.idle", int'(idleA), mCnt[0] == 0 ? 1 : 0);
    checkVal("A.maxSeen", int'(maxA), mMax[0]);
    checkVal("A.underflow", int'(ufA), mUf[0]);
    checkVal("A.ready", int'(readyA), expReady(0));
    checkVal("A.fenceDone", int'(doneA), mPh[0] == 2 ? 1 : 0);
    checkVal("B.count", int'(countB), mCnt[1]);
    checkVal("B.rdata", int'(rdataB), mCnt[1]);
    checkVal("B.idle", int'(idleB), mCnt[1] == 0 ? 1 : 0);
    checkVal("B.maxSeen", int'(maxB), mMax[1]);
    checkVal("B.underflow", int'(ufB), mUf[1]);
    checkVal("B.ready", int'(readyB), expReady(1));
    checkVal("B.fenceDone", int'(doneB), mPh[1] == 2 ? 1 : 0);
  endtask

  task automatic applyStimulus(input logic req, input logic [1:0] ret,
                               input logic fence, input logic clr);
    req_v = req; ret_v = ret; fence_v = fence; clear = clr;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic applyReset();
    req_v = 1'b0; ret_v = 2'b00; fence_v = 1'b0; clear = 1'b0;
    reset_n = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput();
  endtask

  // Asynchronous reset dropped between edges; outputs must clear at once.
  task automatic asyncResetNow();
    #2;
    reset_n = 1'b0;
    #1;
    checkVal("async.countA", int'(countA), 0);
    checkVal("async.maxA", int'(maxA), 0);
    checkVal("async.ufA", int'(ufA), 0);
    checkVal("async.doneA", int'(doneA), 0);
    checkVal("async.readyA", int'(readyA), 1);
    checkVal("async.idleA", int'(idleA), 1);
    checkVal("async.countB", int'(countB), 0);
    modelReset();
    req_v = 1'b0; ret_v = 2'b00; fence_v = 1'b0; clear = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic fenceOn;
    logic [1:0] r;
    reset_n = 1'b0;
    req_v = 1'b0; ret_v = 2'b00; fence_v = 1'b0; clear = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput();
    checkVal("reset.count", int'(countA), 0);
    checkVal("reset.ready", int'(readyA), 1);
    checkVal("reset.idle", int'(idleA), 1);
    checkVal("reset.done", int'(doneA), 0);

    // Five accepts; B throttles at its limit of 4.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    checkVal("five.countA", int'(countA), 5);
    checkVal("five.maxA", int'(maxA), 5);
    checkVal("five.readyA", int'(readyA), 1);
    checkVal("five.rdataA", int'(rdataA), 5);
    checkVal("limit.countB", int'(countB), 4);
    checkVal("limit.readyB", int'(readyB), 0);
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    checkVal("limit.holdB", int'(countB), 4);
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
    checkVal("limit.retB", int'(countB), 3);
    checkVal("limit.readyBack", int'(readyB), 1);
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    checkVal("limit.refillB", int'(countB), 4);

    // Two returns plus an accept from a count of 3.
    applyReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
    checkVal("dualret.countA", int'(countA), 2);

    // Underflow from a count of 1, sticky, then cleared.
    applyReset();
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b11, 1'b0, 1'b0);
    checkVal("uf.count", int'(countA), 0);
    checkVal("uf.set", int'(ufA), 1);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    checkVal("uf.sticky", int'(ufA), 1);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
    checkVal("uf.cleared", int'(ufA), 0);
    checkVal("uf.maxCleared", int'(maxA), 0);

    // Fence with two outstanding and requests pending.
    applyReset();
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
    checkVal("fence.drainReady", int'(readyA), 0);
    checkVal("fence.drainCount", int'(countA), 2);
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0);
    checkVal("fence.empty", int'(countA), 0);
    checkVal("fence.notYet", int'(doneA), 0);
    applyStimulus(1'b1, 2'b00, 1'b1, 1'b0);
    checkVal("fence.done", int'(doneA), 1);
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    checkVal("fence.pulseEnd", int'(doneA), 0);
    checkVal("fence.readyBack", int'(readyA), 1);
    checkVal("fence.noAcceptInDone", int'(countA), 0);

    // Asynchronous reset in the middle of a drain with three outstanding.
    applyReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
    checkVal("midfence.count", int'(countA), 3);
    asyncResetNow();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      checkVal("midfence.noDone", int'(doneA), 0);
    end

    // Randomised traffic with protocol-respecting fences.
    fenceOn = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!fenceOn && mPh[0] == 0 && mPh[1] == 0 && $urandom_range(0, 24) == 0)
        fenceOn = 1'b1;
      r[0] = ($urandom_range(0, 3) == 0);
      r[1] = ($urandom_range(0, 3) == 0);
      applyStimulus($urandom_range(0, 3) != 0, r, fenceOn,
                    $urandom_range(0, 39) == 0);
      if (mPh[0] == 2 || mPh[1] == 2) fenceOn = 1'b0;
      if ($urandom_range(0, 399) == 0) begin
        fenceOn = 1'b0;
        asyncResetNow();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
